icache_line_store: RTL and testbench
====================================

// Module: icache_line_store
// PURPOSE
// - ICache line storage: NUM_WAYS x (NUM_BANKS*2^SETS_PER_BANK_WIDTH) sets of BLOCK_WIDTH-bit lines.
// - Two independent combinational read ports (A = line 1, B = line 2 of a cross-line fetch).
// - Each read port has a lowest-index priority encoder that picks the hit way and muxes its line out.
// - One refill write port; the victim way comes from an internal 4-bit LFSR. Sits beside the tag array in the icache.
// PARAMETERS
// - NUM_WAYS             4    associativity, power of 2, >=2
// - NUM_BANKS            2    banks, power of 2
// - SETS_PER_BANK_WIDTH  5    log2(sets per bank)
// - BLOCK_WIDTH          512  line width in bits
// - WAY_W                derived = $clog2(NUM_WAYS)
// - BANK_W               derived = $clog2(NUM_BANKS)
// PORTS
// - clk_i           in   1                    clock, rising edge
// - rst_i           in   1                    async reset, active-high
// - bank_addr_ra_i  in   SETS_PER_BANK_WIDTH  port A set-in-bank
// - bank_sel_ra_i   in   BANK_W               port A bank
// - hit_ways_a_i    in   NUM_WAYS             port A per-way tag-hit vector
// - rdata_a_o       out  BLOCK_WIDTH          port A selected line
// - hit_a_o         out  1                    |hit_ways_a_i
// - hit_way_a_o     out  WAY_W                port A encoded hit way
// - port B: bank_addr_rb_i, bank_sel_rb_i, hit_ways_b_i, rdata_b_o, hit_b_o, hit_way_b_o
//   same widths and meaning as port A
// - refill_i        in   1                    write line into victim way this edge
// - w_bank_addr_i   in   SETS_PER_BANK_WIDTH  write set-in-bank
// - w_bank_sel_i    in   BANK_W               write bank
// - wdata_i         in   BLOCK_WIDTH          refill line data
// - replace_way_o   out  WAY_W                current victim way = lfsr_q[WAY_W-1:0]
// BEHAVIOUR
// - Storage: array mem[bank][set][way]. Async reset clears every line to 0.
// - Reads are combinational, zero latency:
//   rdata_x_o = mem[bank_sel_rx][bank_addr_rx][hit_way_x_o].
// - Priority encoder: hit_way_x_o = index of lowest set bit of hit_ways_x_i.
//   All-zero vector -> hit_way 0, hit 0, rdata = way 0 line.
// - Write, on posedge with refill_i=1:
//   mem[w_bank_sel_i][w_bank_addr_i][replace_way_o] <= wdata_i. Other ways and sets are untouched.
// - Read during write to the same entry: read returns the OLD data in that cycle and the new data from the next cycle.
// - Ports A and B may address the same or different entries simultaneously, with no conflict.
// - LFSR: lfsr_q, 4 bits, Fibonacci, polynomial x^4+x^3+1.
//   next = {lfsr_q[2:0], lfsr_q[3]^lfsr_q[2]}.
//   Reset value is 4'b0001. It advances only on edges where refill_i=1.
// - LFSR period is 15 states (never 0000):
//   0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000.
// - Victim way for a refill is the pre-advance value.
// - Reset mid-operation: contents go to 0 and LFSR to 0001 immediately. All outputs track the cleared state.
// - Output values while rst_i is held: rdata 0, hit 0, hit_way 0, replace_way_o = 1 (NUM_WAYS=4).
// TESTING
// - Reset, then read any set with hit_ways=0000 -> rdata_a/b=0, hit=0, hit_way=0, replace_way_o=1.
// - Refill set(bank0,addr3) with 0xA5..A5 -> written to way1; replace_way_o becomes 2.
//   Then read A with hit_ways=0010 -> data 0xA5..A5, hit_way=1.
// - 15 consecutive refills -> replace_way_o sequence 1,2,0,1,3,2,1,2,1,3,3,3,2,0,0; the 16th refill wraps back to 1.
// - Set hit_ways_a=1010 -> hit_way_a=1. Set hit_ways_b=1000 -> hit_way_b=3.
//   Both ports read different banks in the same cycle with correct, independent data.
// - Refill and a port-A read of the same entry in one cycle -> old data that cycle, new data the next.
//   Writing bank1 leaves the same addr in bank0 unchanged.
// - Assert rst_i mid-sequence -> all lines 0 and replace_way_o=1 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/icache_line_store.sv
// ICache line storage: NUM_WAYS x (NUM_BANKS * 2^SETS_PER_BANK_WIDTH) lines, two combinational
// read ports with lowest-index hit-way selection, and one refill port whose victim comes from a 4-bit LFSR.
module icache_line_store #(
  parameter int NUM_WAYS            = 4,
  parameter int NUM_BANKS           = 2,
  parameter int SETS_PER_BANK_WIDTH = 5,
  parameter int BLOCK_WIDTH         = 512,
  parameter int WAY_W               = $clog2(NUM_WAYS),
  parameter int BANK_W              = $clog2(NUM_BANKS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [SETS_PER_BANK_WIDTH-1:0] bank_addr_ra_i,
  input  logic [BANK_W-1:0]              bank_sel_ra_i,
  input  logic [NUM_WAYS-1:0]            hit_ways_a_i,
  output logic [BLOCK_WIDTH-1:0]         rdata_a_o,
  output logic                           hit_a_o,
  output logic [WAY_W-1:0]               hit_way_a_o,
  input  logic [SETS_PER_BANK_WIDTH-1:0] bank_addr_rb_i,
  input  logic [BANK_W-1:0]              bank_sel_rb_i,
  input  logic [NUM_WAYS-1:0]            hit_ways_b_i,
  output logic [BLOCK_WIDTH-1:0]         rdata_b_o,
  output logic                           hit_b_o,
  output logic [WAY_W-1:0]               hit_way_b_o,
  input  logic                           refill_i,
  input  logic [SETS_PER_BANK_WIDTH-1:0] w_bank_addr_i,
  input  logic [BANK_W-1:0]              w_bank_sel_i,
  input  logic [BLOCK_WIDTH-1:0]         wdata_i,
  output logic [WAY_W-1:0]               replace_way_o
);

  localparam int NUM_SETS = 1 << SETS_PER_BANK_WIDTH;

  logic [BLOCK_WIDTH-1:0] mem_q [NUM_BANKS][NUM_SETS][NUM_WAYS];
  logic [3:0]             lfsr_q, lfsr_d;

  // Scanning from the top down lets the lowest set bit win.
  function automatic logic [WAY_W-1:0] first_hit(input logic [NUM_WAYS-1:0] ways);
    first_hit = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (ways[i]) first_hit = WAY_W'(i);
    end
  endfunction

  assign hit_way_a_o = first_hit(hit_ways_a_i);
  assign hit_way_b_o = first_hit(hit_ways_b_i);
  assign hit_a_o     = |hit_ways_a_i;
  assign hit_b_o     = |hit_ways_b_i;

  // Reads see the registered array, so a same-cycle refill is visible only after the edge.
  assign rdata_a_o = mem_q[bank_sel_ra_i][bank_addr_ra_i][hit_way_a_o];
  assign rdata_b_o = mem_q[bank_sel_rb_i][bank_addr_rb_i][hit_way_b_o];

  assign replace_way_o = lfsr_q[WAY_W-1:0];

  always_comb begin
    // NOTE: default assigned first so every path drives lfsr_d and no latch is inferred.
    lfsr_d = lfsr_q;
    if (refill_i) lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst_i) lfsr_q <= 4'b0001;
    else       lfsr_q <= lfsr_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the line array is flop-based and must read back as zero right after reset, so it is cleared here.
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          for (int w = 0; w < NUM_WAYS; w++) begin
            mem_q[b][s][w] <= '0;
          end
        end
      end
    end else if (refill_i) begin
      mem_q[w_bank_sel_i][w_bank_addr_i][replace_way_o] <= wdata_i;
    end
  end

endmodule

// File: tb/tb_icache_line_store.sv
// Directed bench for icache_line_store: reset state, refill victim sequence, hit-way priority,
// dual-port independence, read-during-write and asynchronous reset.
module tb_icache_line_store;

  localparam int BW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    bank_addr_ra, bank_addr_rb, w_bank_addr;
  logic          bank_sel_ra, bank_sel_rb, w_bank_sel;
  logic [3:0]    hit_ways_a, hit_ways_b;
  logic [BW-1:0] rdata_a, rdata_b, wdata;
  logic          hit_a, hit_b, refill;
  logic [1:0]    hit_way_a, hit_way_b, replace_way;

  int n_vec = 0;
  int n_err = 0;
  int n_refill = 0;
  int exp_way [16];

  logic [BW-1:0] pat_a5, pat_3c, pat_dead, filler;

  icache_line_store dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bank_addr_ra_i(bank_addr_ra),
    .bank_sel_ra_i (bank_sel_ra),
    .hit_ways_a_i  (hit_ways_a),
    .rdata_a_o     (rdata_a),
    .hit_a_o       (hit_a),
    .hit_way_a_o   (hit_way_a),
    .bank_addr_rb_i(bank_addr_rb),
    .bank_sel_rb_i (bank_sel_rb),
    .hit_ways_b_i  (hit_ways_b),
    .rdata_b_o     (rdata_b),
    .hit_b_o       (hit_b),
    .hit_way_b_o   (hit_way_b),
    .refill_i      (refill),
    .w_bank_addr_i (w_bank_addr),
    .w_bank_sel_i  (w_bank_sel),
    .wdata_i       (wdata),
    .replace_way_o (replace_way)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the victim way before the edge, then writes through it.
  task automatic do_refill(input logic bank, input logic [4:0] addr, input logic [BW-1:0] data);
    w_bank_sel  = bank;
    w_bank_addr = addr;
    wdata       = data;
    refill      = 1'b1;
    #1;
    check($sformatf("victim_%0d", n_refill), BW'(replace_way), BW'(exp_way[n_refill]));
    n_refill++;
    tick();
    refill = 1'b0;
  endtask

  task automatic read_a(input logic bank, input logic [4:0] addr, input logic [3:0] ways);
    bank_sel_ra  = bank;
    bank_addr_ra = addr;
    hit_ways_a   = ways;
  endtask

  task automatic read_b(input logic bank, input logic [4:0] addr, input logic [3:0] ways);
    bank_sel_rb  = bank;
    bank_addr_rb = addr;
    hit_ways_b   = ways;
  endtask

  initial begin
    exp_way = '{1, 2, 0, 1, 3, 2, 1, 2, 1, 3, 3, 3, 2, 0, 0, 1};
    pat_a5   = {64{8'hA5}};
    pat_3c   = {64{8'h3C}};
    pat_dead = {16{32'hDEADBEEF}};

    rst = 1'b1;
    refill = 1'b0;
    w_bank_sel = 1'b0; w_bank_addr = '0; wdata = '0;
    read_a(1'b0, 5'd3, 4'b0000);
    read_b(1'b1, 5'd7, 4'b0000);
    #3;
    check("rst_rdata_a", rdata_a, '0);
    check("rst_rdata_b", rdata_b, '0);
    check("rst_hit_a", BW'(hit_a), '0);
    check("rst_hit_b", BW'(hit_b), '0);
    check("rst_hit_way_a", BW'(hit_way_a), '0);
    check("rst_hit_way_b", BW'(hit_way_b), '0);
    check("rst_replace_way", BW'(replace_way), BW'(1));
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // First refill lands in way 1 of bank0/set3.
    do_refill(1'b0, 5'd3, pat_a5);
    check("replace_after_1", BW'(replace_way), BW'(2));
    read_a(1'b0, 5'd3, 4'b0010);
    #1;
    check("a5_rdata", rdata_a, pat_a5);
    check("a5_hit", BW'(hit_a), BW'(1));
    check("a5_hit_way", BW'(hit_way_a), BW'(1));
    read_a(1'b0, 5'd3, 4'b0001);
    #1;
    check("way0_untouched", rdata_a, '0);
    check("way0_hit_way", BW'(hit_way_a), '0);

    // Lowest-index priority on both ports.
    read_a(1'b0, 5'd3, 4'b1010);
    read_b(1'b0, 5'd3, 4'b1000);
    #1;
    check("prio_a_way", BW'(hit_way_a), BW'(1));
    check("prio_a_rdata", rdata_a, pat_a5);
    check("prio_b_way", BW'(hit_way_b), BW'(3));
    check("prio_b_rdata", rdata_b, '0);
    check("prio_b_hit", BW'(hit_b), BW'(1));

    // Second refill: bank1/set3 way 2; bank0/set3 stays as it was.
    do_refill(1'b1, 5'd3, pat_3c);
    read_a(1'b1, 5'd3, 4'b0100);
    read_b(1'b0, 5'd3, 4'b0100);
    #1;
    check("bank1_way2", rdata_a, pat_3c);
    check("bank0_way2_unchanged", rdata_b, '0);
    read_b(1'b0, 5'd3, 4'b0010);
    #1;
    check("dual_a_bank1", rdata_a, pat_3c);
    check("dual_b_bank0", rdata_b, pat_a5);

    // Third refill (way 0) with port A reading the same entry.
    read_a(1'b0, 5'd5, 4'b0001);
    w_bank_sel = 1'b0; w_bank_addr = 5'd5; wdata = pat_dead; refill = 1'b1;
    #1;
    check("rdw_old", rdata_a, '0);
    check("victim_2", BW'(replace_way), BW'(exp_way[2]));
    n_refill++;
    tick();
    refill = 1'b0;
    check("rdw_new", rdata_a, pat_dead);

    // Remaining refills through one period of the LFSR.
    for (int i = 3; i < 15; i++) begin
      filler = {16{32'(i)}};
      do_refill(1'b1, 5'd31, filler);
    end
    check("wrap_replace", BW'(replace_way), BW'(1));
    filler = {16{32'hF0F0_0015}};
    do_refill(1'b1, 5'd31, filler);
    check("replace_after_16", BW'(replace_way), BW'(2));
    read_b(1'b1, 5'd31, 4'b0010);
    #1;
    check("last_fill_way1", rdata_b, filler);
    read_b(1'b1, 5'd31, 4'b1000);
    #1;
    check("fill_way3", rdata_b, {16{32'(11)}});

    // Asynchronous reset between edges.
    read_a(1'b0, 5'd3, 4'b0010);
    read_b(1'b1, 5'd3, 4'b0100);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rdata_a", rdata_a, '0);
    check("arst_rdata_b", rdata_b, '0);
    check("arst_replace", BW'(replace_way), BW'(1));
    read_a(1'b0, 5'd3, 4'b0000);
    #1;
    check("arst_hit_a", BW'(hit_a), '0);
    check("arst_hit_way_a", BW'(hit_way_a), '0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();

    n_refill = 0;
    do_refill(1'b0, 5'd3, pat_3c);
    read_a(1'b0, 5'd3, 4'b0010);
    #1;
    check("post_rst_refill", rdata_a, pat_3c);
    check("post_rst_replace", BW'(replace_way), BW'(2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
